// File: rtl/digit_serial_addsub.sv
// Digit-serial adder/subtractor: processes one DIGIT-bit slice per cycle, LSB first,
// carrying the carry/borrow between slices in a chain register. Valid/ready on both sides.
module digit_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int N   = WIDTH / DIGIT;
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               sub_q, sub_d;
    logic               chain_q, chain_d;
    logic [KW-1:0]      k_q, k_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic               last_slice;
    logic [DIGIT-1:0]   a_slice, b_slice, s_slice;
    logic [DIGIT:0]     c_chain;

    assign last_slice = (k_q == KW'(N - 1));
    assign a_slice    = a_q[int'(k_q) * DIGIT +: DIGIT];
    assign b_slice    = b_q[int'(k_q) * DIGIT +: DIGIT];
    assign c_chain[0] = chain_q;

    // Per-bit ripple inside the slice; the sum/difference bit is the same XOR in both modes.
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        assign s_slice[gi]   = a_slice[gi] ^ b_slice[gi] ^ c_chain[gi];
        assign c_chain[gi+1] = sub_q
            ? ((~a_slice[gi] & b_slice[gi]) | ((~a_slice[gi] | b_slice[gi]) & c_chain[gi]))
            : ((a_slice[gi] & b_slice[gi]) | ((a_slice[gi] ^ b_slice[gi]) & c_chain[gi]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = BUSY;
            BUSY:    if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        chain_d  = chain_q;
        k_d      = k_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    chain_d = cin;
                    k_d     = '0;
                end
            end
            BUSY: begin
                result_d[int'(k_q) * DIGIT +: DIGIT] = s_slice;
                chain_d = c_chain[DIGIT];
                k_d     = k_q + KW'(1);
                // Flags are taken from the completed result on the final slice only.
                if (last_slice) begin
                    k_d    = '0;
                    cout_d = c_chain[DIGIT];
                    ovf_d  = (sub_q ? (a_q[MSB] != b_q[MSB]) : (a_q[MSB] == b_q[MSB]))
                             && (result_d[MSB] != a_q[MSB]);
                    zero_d = ~|result_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            chain_q  <= 1'b0;
            k_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            chain_q  <= chain_d;
            k_q      <= k_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: directed vectors on a 16/4 instance with a model-driven
// per-cycle monitor, plus random sweeps over several WIDTH/DIGIT configurations.
module tb_digit_serial_addsub;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks      = 0;
    int failures    = 0;
    int sweep_done  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide integer arithmetic, signed overflow by range test.
    function automatic void ref_model(input int w, input longint unsigned ua, input longint unsigned ub,
                                      input bit s, input bit c, output logic [63:0] r,
                                      output logic co, output logic ov, output logic z);
        longint unsigned mask, full;
        longint          sa, sb, sr, lim;
        mask = (64'd1 << w) - 64'd1;
        full = s ? (ua - ub - 64'(c)) : (ua + ub + 64'(c));
        r    = full & mask;
        co   = s ? (ua < ub + 64'(c)) : full[w];
        lim  = longint'(64'd1 << (w - 1));
        sa   = ua[w-1] ? longint'(ua) - 2 * lim : longint'(ua);
        sb   = ub[w-1] ? longint'(ub) - 2 * lim : longint'(ub);
        sr   = s ? (sa - sb - longint'(c)) : (sa + sb + longint'(c));
        ov   = (sr >= lim) || (sr < -lim);
        z    = (r == 64'd0);
    endfunction

    // ---------------- main 16/4 instance ----------------
    logic        rst = 1'b1, in_valid = 1'b0, sub = 1'b0, cin = 1'b0, out_ready = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        in_ready, out_valid, cout, ovf, zero;
    logic [15:0] result;

    digit_serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf), .zero(zero)
    );

    // Monitor: tracks the outstanding operation and checks the DUT against the model every cycle.
    int          cyc = 0, acc_cyc = 0;
    bit          pend = 1'b0, seen = 1'b0;
    logic [63:0] e_r;
    logic        e_co, e_ov, e_z;

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pend = 1'b0;
        end else begin
            chk("mon_in_ready", 64'(in_ready), 64'(!pend));
            if (!pend) chk("mon_out_valid_idle", 64'(out_valid), 64'd0);
            if (pend && out_valid === 1'b1) begin
                if (!seen) begin
                    chk("mon_latency", 64'(cyc - acc_cyc), 64'd5);
                    seen = 1'b1;
                end
                chk("mon_result", 64'(result), e_r);
                chk("mon_flags", 64'({cout, ovf, zero}), 64'({e_co, e_ov, e_z}));
            end
            if (pend && out_valid && out_ready) begin
                pend = 1'b0;
                $display("txn done: result=0x%04h cout=%0b ovf=%0b zero=%0b", result, cout, ovf, zero);
            end else if (!pend && in_valid && in_ready) begin
                ref_model(16, 64'(a), 64'(b), sub, cin, e_r, e_co, e_ov, e_z);
                pend    = 1'b1;
                seen    = 1'b0;
                acc_cyc = cyc;
            end
        end
    end

    task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic is, input logic ic,
                          input int hold, output logic [15:0] r, output logic co, output logic ov,
                          output logic z, output int lat);
        int n;
        @(posedge clk); #1;
        a = ia; b = ib; sub = is; cin = ic; in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = ~ia; b = ib ^ 16'h5A5A; sub = ~is; cin = ~ic;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (lat >= 100) chk("done_timeout", 64'd0, 64'd1);
        r = result; co = cout; ov = ovf; z = zero;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; a = 16'(i * 16'h1111); b = 16'h0F0F; sub = 1'b0; cin = 1'b1;
            @(posedge clk); #1;
            chk("hold_result", 64'(result), 64'(r));
            chk("hold_flags", 64'({cout, ovf, zero}), 64'({co, ov, z}));
            chk("hold_out_valid", 64'(out_valid), 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", 64'(out_valid), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    // ---------------- random sweep instances ----------------
    for (genvar gi = 0; gi < 6; gi++) begin : g_sw
        localparam int W = (gi == 5) ? 32 : 16;
        localparam int D = (gi == 5) ? 8 : (1 << gi);
        localparam int N = W / D;

        logic         s_rst = 1'b1, s_iv = 1'b0, s_sub = 1'b0, s_cin = 1'b0, s_or = 1'b0;
        logic [W-1:0] s_a = '0, s_b = '0;
        logic         s_ir, s_ov, s_co, s_ovf, s_z;
        logic [W-1:0] s_r;

        digit_serial_addsub #(.WIDTH(W), .DIGIT(D)) u_dut (
            .clk(clk), .rst(s_rst), .in_valid(s_iv), .in_ready(s_ir),
            .a(s_a), .b(s_b), .sub(s_sub), .cin(s_cin),
            .out_valid(s_ov), .out_ready(s_or),
            .result(s_r), .cout(s_co), .ovf(s_ovf), .zero(s_z)
        );

        initial begin
            logic [63:0] er;
            logic        eco, eov, ez;
            int          n, lat, hold;
            repeat (2) @(posedge clk);
            #1 s_rst = 1'b0;
            for (int t = 0; t < 1000; t++) begin
                s_a   = W'({$urandom, $urandom});
                s_b   = W'({$urandom, $urandom});
                s_sub = 1'($urandom_range(0, 1));
                s_cin = 1'($urandom_range(0, 1));
                s_iv  = 1'b1;
                ref_model(W, 64'(s_a), 64'(s_b), s_sub, s_cin, er, eco, eov, ez);
                n = 0;
                while (s_ir !== 1'b1 && n < 50) begin
                    @(posedge clk); #1;
                    n++;
                end
                if (n >= 50) chk($sformatf("sweep%0d_accept_timeout", gi), 64'd0, 64'd1);
                @(posedge clk); #1;
                s_iv = 1'b0; s_a = ~s_a; s_b = W'($urandom); s_sub = ~s_sub; s_cin = ~s_cin;
                lat = 0;
                while (s_ov !== 1'b1 && lat < 100) begin
                    @(posedge clk); #1;
                    lat++;
                end
                chk($sformatf("sweep%0d_latency", gi), 64'(lat), 64'(N));
                chk($sformatf("sweep%0d_result", gi), 64'(s_r), er);
                chk($sformatf("sweep%0d_cout", gi), 64'(s_co), 64'(eco));
                chk($sformatf("sweep%0d_ovf", gi), 64'(s_ovf), 64'(eov));
                chk($sformatf("sweep%0d_zero", gi), 64'(s_z), 64'(ez));
                hold = $urandom_range(0, 2);
                repeat (hold) begin
                    @(posedge clk); #1;
                end
                s_or = 1'b1;
                @(posedge clk); #1;
                s_or = 1'b0;
            end
            $display("sweep W=%0d D=%0d: 1000 transactions issued", W, D);
            sweep_done++;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [15:0] r;
        logic        co, ov, z;
        logic [63:0] mr;
        logic        mco, mov, mz;
        int          lat, n;

        // Pin the model itself with hand-computed values.
        ref_model(16, 64'hAAAA, 64'h5555, 1'b1, 1'b0, mr, mco, mov, mz);
        chk("model_sub_aaaa", {mr[15:0], mco, mov, mz}, {16'h5555, 3'b010});
        ref_model(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0, mr, mco, mov, mz);
        chk("model_add_7fff", {mr[15:0], mco, mov, mz}, {16'h8000, 3'b010});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_result", 64'(result), 64'd0);
        chk("reset_flags", 64'({cout, ovf, zero}), 64'd0);
        rst = 1'b0;

        run_op(16'hAAAA, 16'h5555, 1'b1, 1'b0, 5, r, co, ov, z, lat);
        $display("txn sub AAAA-5555: result=0x%04h cout=%0b ovf=%0b zero=%0b lat=%0d", r, co, ov, z, lat);
        chk("sub_aaaa_latency", 64'(lat), 64'd4);
        chk("sub_aaaa_result", 64'(r), 64'h5555);
        chk("sub_aaaa_flags", 64'({co, ov, z}), 64'b010);

        run_op(16'h0000, 16'h0001, 1'b1, 1'b0, 0, r, co, ov, z, lat);
        $display("txn sub 0000-0001: result=0x%04h cout=%0b ovf=%0b zero=%0b", r, co, ov, z);
        chk("sub_0_1_result", 64'(r), 64'hFFFF);
        chk("sub_0_1_flags", 64'({co, ov, z}), 64'b100);

        run_op(16'h1234, 16'h1233, 1'b1, 1'b1, 1, r, co, ov, z, lat);
        $display("txn sub 1234-1233-1: result=0x%04h cout=%0b ovf=%0b zero=%0b", r, co, ov, z);
        chk("sub_borrowin_result", 64'(r), 64'h0000);
        chk("sub_borrowin_flags", 64'({co, ov, z}), 64'b001);

        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, r, co, ov, z, lat);
        $display("txn add FFFF+0001: result=0x%04h cout=%0b ovf=%0b zero=%0b", r, co, ov, z);
        chk("add_wrap_result", 64'(r), 64'h0000);
        chk("add_wrap_flags", 64'({co, ov, z}), 64'b101);

        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 2, r, co, ov, z, lat);
        $display("txn add 7FFF+0001: result=0x%04h cout=%0b ovf=%0b zero=%0b", r, co, ov, z);
        chk("add_ovf_result", 64'(r), 64'h8000);
        chk("add_ovf_flags", 64'({co, ov, z}), 64'b010);

        // Abort an operation two slices in; nothing may come out for it.
        @(posedge clk); #1;
        chk("abort_pre_ready", 64'(in_ready), 64'd1);
        a = 16'h1111; b = 16'h2222; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        $display("txn reset mid-busy: in_ready=%0b out_valid=%0b result=0x%04h", in_ready, out_valid, result);
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort_no_out_valid", 64'(out_valid), 64'd0);
        end

        run_op(16'h1234, 16'h1111, 1'b0, 1'b1, 0, r, co, ov, z, lat);
        $display("txn add 1234+1111+1: result=0x%04h cout=%0b ovf=%0b zero=%0b", r, co, ov, z);
        chk("post_abort_result", 64'(r), 64'h2346);
        chk("post_abort_flags", 64'({co, ov, z}), 64'b000);

        n = 0;
        while (sweep_done < 6 && n < 60000) begin
            @(posedge clk);
            n++;
        end
        if (sweep_done < 6) chk("sweep_timeout", 64'(sweep_done), 64'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
